// File: rtl/core_pkg.sv
// Shared core types: hazard controller state encoding and the register-index width.
package core_pkg;
  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_MEM_WAIT,
    S_ERROR
  } hazard_state_t;

  // x0 is hardwired to zero, so a write to it can never be a true dependency.
  function automatic logic regDepends(input logic [REG_W-1:0] src, input logic [REG_W-1:0] dst,
                                      input logic uses);
    return uses && (dst != '0) && (src == dst);
  endfunction
endpackage

// File: rtl/hazard_ctrl_mem_wait_timer.sv
// Counts data-memory wait cycles; hit flags the cycle whose increment reaches TIMEOUT.
module mem_wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int W       = $clog2(TIMEOUT + 1)
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic clr,
  input  logic en,
  output logic hit
);
  logic [W-1:0] count;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != W'(TIMEOUT))) begin
      count <= count + W'(1);
    end
  end

  assign hit = en && (count == W'(TIMEOUT - 1));
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32 pipeline: load-use bubble, branch flush, memory freeze.
// HAZARD_STATS_EN enables the saturating StallCycles/FlushCount statistics counters.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int REG_W       = core_pkg::REG_W,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [REG_W-1:0] ID_Rs1,
  input  logic [REG_W-1:0] ID_Rs2,
  input  logic             ID_UsesRs1,
  input  logic             ID_UsesRs2,
  input  logic [REG_W-1:0] EX_Rd,
  input  logic             EX_MemRead,
  input  logic             EX_BranchTkn,
  input  logic             MEM_Req,
  input  logic             MEM_Ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             Stall_All,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);
  hazard_state_t state, stateNxt;
  logic          loadUse;
  logic          memFreeze;
  logic          tmrHit;

  assign loadUse = EX_MemRead &&
                   (regDepends(ID_Rs1, EX_Rd, ID_UsesRs1) || regDepends(ID_Rs2, EX_Rd, ID_UsesRs2));

  // In MEM_WAIT only MEM_Ready matters: the request is still parked in MEM.
  assign memFreeze = ((state == S_RUN) && MEM_Req && !MEM_Ready) ||
                     ((state == S_MEM_WAIT) && !MEM_Ready);

  mem_wait_timer #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .clr     (!memFreeze),
    .en      (memFreeze),
    .hit     (tmrHit)
  );

  always_comb begin
    PC_Write     = 1'b0;
    IF_ID_Write  = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    Stall_All    = 1'b0;
    stateNxt     = state;
    case (state)
      S_BOOT: begin
        IF_ID_Flush  = 1'b1;
        ID_EX_Bubble = 1'b1;
        stateNxt     = S_RUN;
      end
      S_RUN, S_MEM_WAIT: begin
        if (memFreeze) begin
          Stall_All = 1'b1;
          stateNxt  = tmrHit ? S_ERROR : S_MEM_WAIT;
        end else begin
          PC_Write    = 1'b1;
          IF_ID_Write = 1'b1;
          stateNxt    = S_RUN;
          // A taken branch discards the ID instruction, so its load-use match is moot.
          if (EX_BranchTkn) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
          end else if (loadUse) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
          end
        end
      end
      S_ERROR: begin
        Stall_All = 1'b1;
      end
      default: begin
        stateNxt = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= S_BOOT;
      MemErr <= 1'b0;
    end else begin
      state <= stateNxt;
      if (stateNxt == S_ERROR) MemErr <= 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (((state == S_RUN) || (state == S_MEM_WAIT)) && !PC_Write && (stallCnt != '1))
        stallCnt <= stallCnt + CNT_W'(1);
      if ((state == S_RUN) && IF_ID_Flush && (flushCnt != '1))
        flushCnt <= flushCnt + CNT_W'(1);
    end
  end

  assign StallCycles = stallCnt;
  assign FlushCount  = flushCnt;
`else
  assign StallCycles = '0;
  assign FlushCount  = '0;
`endif
endmodule
